// File: rtl/reg_scoreboard.sv
// ============================================================================
// Module   : reg_scoreboard
// Brief    : Per-register saturating in-flight write counters for the R/F/M
//            groups; raises a decode hazard stall on RAW or WAW overflow.
//            Optional macro SCOREBOARD_BYPASS_EN: same-cycle writeback release.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_scoreboard #(
    parameter int CNT_W = 2,
    parameter int NREG  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [1:0] rs1_group,
    input  logic [4:0] rs1_index,
    input  logic [1:0] rs2_group,
    input  logic [4:0] rs2_index,
    input  logic [1:0] rs3_group,
    input  logic [4:0] rs3_index,
    input  logic [1:0] rd_group,
    input  logic [4:0] rd_index,
    input  logic       issue_fire,
    input  logic       wb_valid,
    input  logic [1:0] wb_group,
    input  logic [4:0] wb_index,
    input  logic       flush,
    output logic       conflict,
    output logic       pending_any,
    output logic       wb_err
);

    localparam logic [1:0] REG_GROUP_R       = 2'd0;
    localparam logic [1:0] REG_GROUP_F       = 2'd1;
    localparam logic [1:0] REG_GROUP_M       = 2'd2;
    localparam logic [1:0] REG_GROUP_INVALID = 2'd3;
    localparam int         NGRP              = 3;

    localparam logic [CNT_W-1:0] c_cnt_zero = '0;
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_sat  = '1;

    function automatic logic is_tracked(input logic [1:0] grp, input logic [4:0] idx);
        return (grp != REG_GROUP_INVALID) &&
               !((grp == REG_GROUP_R) && (idx == 5'd0)) &&
               (int'(idx) < NREG);
    endfunction

    function automatic logic names_reg(input logic [1:0] grp, input logic [4:0] idx,
                                       input int g, input int i);
        return (grp == 2'(g)) && (idx == 5'(i));
    endfunction

    logic [CNT_W-1:0] cnt_q [NGRP][NREG];
    logic [CNT_W-1:0] cnt_d [NGRP][NREG];
    logic             pending_any_q, pending_any_d;
    logic             wb_err_q, wb_err_d;

    logic w_rs1_trk, w_rs2_trk, w_rs3_trk, w_rd_trk, w_wb_trk;
    logic w_src_hit, w_rd_sat;
    logic w_inc         [NGRP][NREG];
    logic w_dec         [NGRP][NREG];
    logic w_bypass_mask [NGRP][NREG];

    assign w_rs1_trk = is_tracked(rs1_group, rs1_index);
    assign w_rs2_trk = is_tracked(rs2_group, rs2_index);
    assign w_rs3_trk = is_tracked(rs3_group, rs3_index);
    assign w_rd_trk  = is_tracked(rd_group, rd_index);
    assign w_wb_trk  = is_tracked(wb_group, wb_index);

    always_comb begin
        for (int g = 0; g < NGRP; g++) begin
            for (int i = 0; i < NREG; i++) begin
                w_inc[g][i] = issue_fire && w_rd_trk && names_reg(rd_group, rd_index, g, i);
                w_dec[g][i] = wb_valid && w_wb_trk && names_reg(wb_group, wb_index, g, i);
            end
        end
    end

    // A source whose last outstanding write retires this cycle may be released
    // early; only legal when the regfile forwards the write to the read.
    always_comb begin
        for (int g = 0; g < NGRP; g++) begin
            for (int i = 0; i < NREG; i++) begin
`ifdef SCOREBOARD_BYPASS_EN
                w_bypass_mask[g][i] = w_dec[g][i] && (cnt_q[g][i] == c_cnt_one);
`else
                w_bypass_mask[g][i] = 1'b0;
`endif
            end
        end
    end

    always_comb begin
        w_src_hit = 1'b0;
        w_rd_sat  = 1'b0;
        for (int g = 0; g < NGRP; g++) begin
            for (int i = 0; i < NREG; i++) begin
                if (((w_rs1_trk && names_reg(rs1_group, rs1_index, g, i)) ||
                     (w_rs2_trk && names_reg(rs2_group, rs2_index, g, i)) ||
                     (w_rs3_trk && names_reg(rs3_group, rs3_index, g, i))) &&
                    (cnt_q[g][i] != c_cnt_zero) && !w_bypass_mask[g][i]) begin
                    w_src_hit = 1'b1;
                end
                if (w_rd_trk && names_reg(rd_group, rd_index, g, i) &&
                    (cnt_q[g][i] == c_cnt_sat)) begin
                    w_rd_sat = 1'b1;
                end
            end
        end
    end

    assign conflict = id_valid && (w_src_hit || w_rd_sat);

    always_comb begin
        cnt_d         = cnt_q;
        wb_err_d      = wb_err_q;
        pending_any_d = 1'b0;
        for (int g = 0; g < NGRP; g++) begin
            for (int i = 0; i < NREG; i++) begin
                if (flush) begin
                    cnt_d[g][i] = c_cnt_zero;
                end else if (w_dec[g][i] && (cnt_q[g][i] == c_cnt_zero)) begin
                    // Spurious retire: flag it and keep any same-cycle issue.
                    wb_err_d = 1'b1;
                    if (w_inc[g][i]) begin
                        cnt_d[g][i] = c_cnt_one;
                    end
                end else if (w_inc[g][i] && !w_dec[g][i]) begin
                    if (cnt_q[g][i] != c_cnt_sat) begin
                        cnt_d[g][i] = cnt_q[g][i] + c_cnt_one;
                    end
                end else if (w_dec[g][i] && !w_inc[g][i]) begin
                    cnt_d[g][i] = cnt_q[g][i] - c_cnt_one;
                end
                if (cnt_d[g][i] != c_cnt_zero) begin
                    pending_any_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < NGRP; g++) begin
                for (int i = 0; i < NREG; i++) begin
                    cnt_q[g][i] <= c_cnt_zero;
                end
            end
            pending_any_q <= 1'b0;
            wb_err_q      <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            pending_any_q <= pending_any_d;
            wb_err_q      <= wb_err_d;
        end
    end

    assign pending_any = pending_any_q;
    assign wb_err      = wb_err_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
// ============================================================================
// Module   : tb_reg_scoreboard
// Brief    : Scoreboard bench for reg_scoreboard; expectations are queued as
//            stimulus is driven and popped when outputs are sampled.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_scoreboard;

    localparam logic [1:0] G_R   = 2'd0;
    localparam logic [1:0] G_F   = 2'd1;
    localparam logic [1:0] G_M   = 2'd2;
    localparam logic [1:0] G_INV = 2'd3;
`ifdef SCOREBOARD_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [1:0] rs1_group, rs2_group, rs3_group, rd_group, wb_group;
    logic [4:0] rs1_index, rs2_index, rs3_index, rd_index, wb_index;
    logic       issue_fire, wb_valid, flush;
    logic       conflict, pending_any, wb_err;

    typedef struct {
        string      name;
        logic [2:0] v;   // {conflict, pending_any, wb_err}
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    reg_scoreboard #(.CNT_W(2), .NREG(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .rs1_group  (rs1_group),
        .rs1_index  (rs1_index),
        .rs2_group  (rs2_group),
        .rs2_index  (rs2_index),
        .rs3_group  (rs3_group),
        .rs3_index  (rs3_index),
        .rd_group   (rd_group),
        .rd_index   (rd_index),
        .issue_fire (issue_fire),
        .wb_valid   (wb_valid),
        .wb_group   (wb_group),
        .wb_index   (wb_index),
        .flush      (flush),
        .conflict   (conflict),
        .pending_any(pending_any),
        .wb_err     (wb_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input string n, input logic [2:0] v);
        exp_t t;
        t.name = n;
        t.v    = v;
        return t;
    endfunction

    task automatic drive_idle();
        id_valid   = 1'b0;
        issue_fire = 1'b0;
        wb_valid   = 1'b0;
        flush      = 1'b0;
        rs1_group  = G_INV; rs1_index = 5'd0;
        rs2_group  = G_INV; rs2_index = 5'd0;
        rs3_group  = G_INV; rs3_index = 5'd0;
        rd_group   = G_INV; rd_index  = 5'd0;
        wb_group   = G_INV; wb_index  = 5'd0;
    endtask

    task automatic step_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        step_edge();
        step_edge();
        rst = 1'b0;
        id_valid = 1'b1; rs1_group = G_R; rs1_index = 5'd5;
        exp_q.push_back(mk("reset_state", 3'b000));
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if ({conflict, pending_any, wb_err} !== e.v) begin
            n_fail++;
            $display("FAIL %s: got {conflict,pending,wb_err}=%b expected %b", e.name, {conflict, pending_any, wb_err}, e.v);
        end
        step_edge();
        drive_idle();
    endtask

    task automatic test_raw();
        id_valid = 1'b1; issue_fire = 1'b1; rd_group = G_F; rd_index = 5'd3;
        exp_q.push_back(mk("raw_issue", 3'b000));
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if ({conflict, pending_any, wb_err} !== e.v) begin
            n_fail++;
            $display("FAIL %s: got {conflict,pending,wb_err}=%b expected %b", e.name, {conflict, pending_any, wb_err}, e.v);
        end
        step_edge();
        issue_fire = 1'b0; rd_group = G_INV; rs2_group = G_F; rs2_index = 5'd3;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(mk("raw_dependent", 3'b110));
            @(negedge clk);
            e = exp_q.pop_front(); n_checks++;
            if ({conflict, pending_any, wb_err} !== e.v) begin
                n_fail++;
                $display("FAIL %s[%0d]: got {conflict,pending,wb_err}=%b expected %b", e.name, k, {conflict, pending_any, wb_err}, e.v);
            end
            step_edge();
        end
        wb_valid = 1'b1; wb_group = G_F; wb_index = 5'd3;
        exp_q.push_back(mk("raw_wb_cycle", {~BYP, 2'b10}));
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if ({conflict, pending_any, wb_err} !== e.v) begin
            n_fail++;
            $display("FAIL %s: got {conflict,pending,wb_err}=%b expected %b", e.name, {conflict, pending_any, wb_err}, e.v);
        end
        step_edge();
        wb_valid = 1'b0;
        exp_q.push_back(mk("raw_released", 3'b000));
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if ({conflict, pending_any, wb_err} !== e.v) begin
            n_fail++;
            $display("FAIL %s: got {conflict,pending,wb_err}=%b expected %b", e.name, {conflict, pending_any, wb_err}, e.v);
        end
        step_edge();
        drive_idle();
    endtask

    task automatic test_waw_saturation();
        id_valid = 1'b1; rd_group = G_R; rd_index = 5'd7;
        // Four fires: three legal, the fourth violates protocol and must not wrap.
        for (int k = 0; k < 4; k++) begin
            issue_fire = 1'b1;
            exp_q.push_back(mk("waw_issue", {(k == 3), (k > 0), 1'b0}));
            @(negedge clk);
            e = exp_q.pop_front(); n_checks++;
            if ({conflict, pending_any, wb_err} !== e.v) begin
                n_fail++;
                $display("FAIL %s[%0d]: got {conflict,pending,wb_err}=%b expected %b", e.name, k, {conflict, pending_any, wb_err}, e.v);
            end
            step_edge();
        end
        issue_fire = 1'b0;
        wb_valid = 1'b1; wb_group = G_R; wb_index = 5'd7;
        exp_q.push_back(mk("waw_no_wrap", 3'b110));
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if ({conflict, pending_any, wb_err} !== e.v) begin
            n_fail++;
            $display("FAIL %s: got {conflict,pending,wb_err}=%b expected %b", e.name, {conflict, pending_any, wb_err}, e.v);
        end
        step_edge();
        wb_valid = 1'b0;
        exp_q.push_back(mk("waw_released", 3'b010));
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if ({conflict, pending_any, wb_err} !== e.v) begin
            n_fail++;
            $display("FAIL %s: got {conflict,pending,wb_err}=%b expected %b", e.name, {conflict, pending_any, wb_err}, e.v);
        end
        step_edge();
        id_valid = 1'b0; wb_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(mk("waw_drain", 3'b010));
            @(negedge clk);
            e = exp_q.pop_front(); n_checks++;
            if ({conflict, pending_any, wb_err} !== e.v) begin
                n_fail++;
                $display("FAIL %s[%0d]: got {conflict,pending,wb_err}=%b expected %b", e.name, k, {conflict, pending_any, wb_err}, e.v);
            end
            step_edge();
        end
        wb_valid = 1'b0;
        exp_q.push_back(mk("waw_drained", 3'b000));
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if ({conflict, pending_any, wb_err} !== e.v) begin
            n_fail++;
            $display("FAIL %s: got {conflict,pending,wb_err}=%b expected %b", e.name, {conflict, pending_any, wb_err}, e.v);
        end
        step_edge();
        drive_idle();
    endtask

    task automatic test_untracked_and_err();
        id_valid = 1'b1; issue_fire = 1'b1; rd_group = G_R; rd_index = 5'd0;
        step_edge();
        rd_group = G_INV; rd_index = 5'd5;
        step_edge();
        issue_fire = 1'b0; rd_group = G_INV;
        rs1_group = G_R; rs1_index = 5'd0;
        wb_valid = 1'b1; wb_group = G_R; wb_index = 5'd9;
        exp_q.push_back(mk("untracked_ignored", 3'b000));
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if ({conflict, pending_any, wb_err} !== e.v) begin
            n_fail++;
            $display("FAIL %s: got {conflict,pending,wb_err}=%b expected %b", e.name, {conflict, pending_any, wb_err}, e.v);
        end
        step_edge();
        wb_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(mk("wb_err_sticky", 3'b001));
            @(negedge clk);
            e = exp_q.pop_front(); n_checks++;
            if ({conflict, pending_any, wb_err} !== e.v) begin
                n_fail++;
                $display("FAIL %s[%0d]: got {conflict,pending,wb_err}=%b expected %b", e.name, k, {conflict, pending_any, wb_err}, e.v);
            end
            step_edge();
        end
        issue_fire = 1'b1; rd_group = G_F; rd_index = 5'd1; rs1_group = G_INV;
        step_edge();
        issue_fire = 1'b0; rd_group = G_INV; rs1_group = G_F; rs1_index = 5'd1;
        exp_q.push_back(mk("async_pre", 3'b111));
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if ({conflict, pending_any, wb_err} !== e.v) begin
            n_fail++;
            $display("FAIL %s: got {conflict,pending,wb_err}=%b expected %b", e.name, {conflict, pending_any, wb_err}, e.v);
        end
        step_edge();
        #2 rst = 1'b1;
        exp_q.push_back(mk("async_reset", 3'b000));
        #1;
        e = exp_q.pop_front(); n_checks++;
        if ({conflict, pending_any, wb_err} !== e.v) begin
            n_fail++;
            $display("FAIL %s: got {conflict,pending,wb_err}=%b expected %b", e.name, {conflict, pending_any, wb_err}, e.v);
        end
        #1 rst = 1'b0;
        step_edge();
        drive_idle();
    endtask

    task automatic test_same_cycle_and_flush();
        id_valid = 1'b1; issue_fire = 1'b1; rd_group = G_M; rd_index = 5'd2;
        step_edge();
        wb_valid = 1'b1; wb_group = G_M; wb_index = 5'd2;
        exp_q.push_back(mk("same_cycle_drive", 3'b010));
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if ({conflict, pending_any, wb_err} !== e.v) begin
            n_fail++;
            $display("FAIL %s: got {conflict,pending,wb_err}=%b expected %b", e.name, {conflict, pending_any, wb_err}, e.v);
        end
        step_edge();
        issue_fire = 1'b0; wb_valid = 1'b0; rd_group = G_INV;
        rs1_group = G_M; rs1_index = 5'd2;
        exp_q.push_back(mk("same_cycle_net0", 3'b110));
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if ({conflict, pending_any, wb_err} !== e.v) begin
            n_fail++;
            $display("FAIL %s: got {conflict,pending,wb_err}=%b expected %b", e.name, {conflict, pending_any, wb_err}, e.v);
        end
        step_edge();
        // Flush beats a same-cycle issue and a writeback to an idle register.
        flush = 1'b1; issue_fire = 1'b1; rd_group = G_R; rd_index = 5'd4;
        wb_valid = 1'b1; wb_group = G_R; wb_index = 5'd9;
        exp_q.push_back(mk("flush_cycle", 3'b110));
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if ({conflict, pending_any, wb_err} !== e.v) begin
            n_fail++;
            $display("FAIL %s: got {conflict,pending,wb_err}=%b expected %b", e.name, {conflict, pending_any, wb_err}, e.v);
        end
        step_edge();
        flush = 1'b0; issue_fire = 1'b0; wb_valid = 1'b0; rd_group = G_INV;
        rs1_group = G_R; rs1_index = 5'd4; rs2_group = G_M; rs2_index = 5'd2;
        exp_q.push_back(mk("flush_cleared", 3'b000));
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if ({conflict, pending_any, wb_err} !== e.v) begin
            n_fail++;
            $display("FAIL %s: got {conflict,pending,wb_err}=%b expected %b", e.name, {conflict, pending_any, wb_err}, e.v);
        end
        step_edge();
        drive_idle();
    endtask

    task automatic test_self_dep();
        id_valid = 1'b1; issue_fire = 1'b1; rd_group = G_R; rd_index = 5'd10;
        rs1_group = G_R; rs1_index = 5'd10; rs3_group = G_R; rs3_index = 5'd10;
        exp_q.push_back(mk("self_dep_issue", 3'b000));
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if ({conflict, pending_any, wb_err} !== e.v) begin
            n_fail++;
            $display("FAIL %s: got {conflict,pending,wb_err}=%b expected %b", e.name, {conflict, pending_any, wb_err}, e.v);
        end
        step_edge();
        issue_fire = 1'b0; rd_group = G_INV;
        exp_q.push_back(mk("dup_sources", 3'b110));
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if ({conflict, pending_any, wb_err} !== e.v) begin
            n_fail++;
            $display("FAIL %s: got {conflict,pending,wb_err}=%b expected %b", e.name, {conflict, pending_any, wb_err}, e.v);
        end
        step_edge();
        id_valid = 1'b0; wb_valid = 1'b1; wb_group = G_R; wb_index = 5'd10;
        step_edge();
        wb_valid = 1'b0; id_valid = 1'b1;
        exp_q.push_back(mk("dup_released", 3'b000));
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if ({conflict, pending_any, wb_err} !== e.v) begin
            n_fail++;
            $display("FAIL %s: got {conflict,pending,wb_err}=%b expected %b", e.name, {conflict, pending_any, wb_err}, e.v);
        end
        step_edge();
        drive_idle();
    endtask

    task automatic test_bypass();
        id_valid = 1'b1; issue_fire = 1'b1; rd_group = G_R; rd_index = 5'd6;
        step_edge();
        issue_fire = 1'b0; rd_group = G_INV;
        rs1_group = G_R; rs1_index = 5'd6;
        wb_valid = 1'b1; wb_group = G_R; wb_index = 5'd6;
        exp_q.push_back(mk("bypass_wb_cycle", {~BYP, 2'b10}));
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if ({conflict, pending_any, wb_err} !== e.v) begin
            n_fail++;
            $display("FAIL %s: got {conflict,pending,wb_err}=%b expected %b", e.name, {conflict, pending_any, wb_err}, e.v);
        end
        step_edge();
        wb_valid = 1'b0;
        exp_q.push_back(mk("bypass_next", 3'b000));
        @(negedge clk);
        e = exp_q.pop_front(); n_checks++;
        if ({conflict, pending_any, wb_err} !== e.v) begin
            n_fail++;
            $display("FAIL %s: got {conflict,pending,wb_err}=%b expected %b", e.name, {conflict, pending_any, wb_err}, e.v);
        end
        step_edge();
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_raw();
        test_waw_saturation();
        test_untracked_and_err();
        test_same_cycle_and_flush();
        test_self_dep();
        test_bypass();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
